// File: rtl/serial_latch_receiver.sv
// serial_latch_receiver
// Receives a shift-register style serial stream (data, shift clock, latch)
// in the system clock domain. Bits are shifted in MSB-first on each shift
// clock rising edge; a latch rising edge either transfers a complete frame
// to data_out or flags a framing error.
module serial_latch_receiver #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_clk,
  input  logic             ser_data,
  input  logic             ser_latch,
  output logic [WIDTH-1:0] data_out,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [CNT_W-1:0] bit_count,
  output logic [ERR_W-1:0] err_count
);

  // Full frame and overflow-marker values of the bit counter
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  logic             clk_s1, clk_s2, clk_s3;
  logic             data_s1, data_s2;
  logic             latch_s1, latch_s2, latch_s3;
  logic             shift_edge, latch_edge;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_post;
  logic [CNT_W-1:0] count_post;
  logic             frame_ok;

  // Synchronizers: two flops per line, a third on clock/latch for edge detect.
  // Data uses the same depth so data_s2 lines up with the ser_clk edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1   <= 1'b0;
      clk_s2   <= 1'b0;
      clk_s3   <= 1'b0;
      data_s1  <= 1'b0;
      data_s2  <= 1'b0;
      latch_s1 <= 1'b0;
      latch_s2 <= 1'b0;
      latch_s3 <= 1'b0;
    end else begin
      clk_s1   <= ser_clk;
      clk_s2   <= clk_s1;
      clk_s3   <= clk_s2;
      data_s1  <= ser_data;
      data_s2  <= data_s1;
      latch_s1 <= ser_latch;
      latch_s2 <= latch_s1;
      latch_s3 <= latch_s2;
    end
  end

  // Rising-edge strobes in the clk domain
  assign shift_edge = clk_s2 & ~clk_s3;
  assign latch_edge = latch_s2 & ~latch_s3;

  // Post-shift view of the shift register and counter, so a shift and a
  // latch landing in the same cycle include the new bit in the frame.
  always_comb begin
    shreg_post = shreg;
    count_post = bit_count;
    if (shift_edge) begin
      shreg_post = {shreg[WIDTH-2:0], data_s2};
      if (bit_count != CNT_SAT) begin
        count_post = bit_count + CNT_W'(1);
      end
    end
  end

  assign frame_ok = (count_post == CNT_FULL);

  // Shift register; never cleared by a latch, stale bits get shifted out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else begin
      shreg <= shreg_post;
    end
  end

  // Bit counter: saturating count of bits since the last latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_count <= '0;
    end else if (latch_edge) begin
      bit_count <= '0;
    end else begin
      bit_count <= count_post;
    end
  end

  // Frame transfer and one-cycle status pulses on a latch edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= latch_edge & frame_ok;
      frame_err   <= latch_edge & ~frame_ok;
      if (latch_edge && frame_ok) begin
        data_out <= shreg_post;
      end
    end
  end

  // Saturating framing-error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (latch_edge && !frame_ok && (err_count != '1)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule
